// File: rtl/image_write_pkg.sv
// Shared constants and FSM encoding for the image_write frame sink.
// Parameter defaults live here so the top and the frame buffer agree on them.
package image_write_pkg;

   localparam int WIDTH_DEF  = 10;
   localparam int HEIGHT_DEF = 5;
   localparam int ADDR_W_DEF = 19;
   localparam int BPP        = 3;
   localparam int BEAT_BYTES = 2 * BPP;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ARMED   = 2'b01,
      ST_CAPTURE = 2'b10,
      ST_DONE    = 2'b11
   } state_t;

endpackage

// File: rtl/image_write_frame_buffer_ram.sv
// Byte-wide frame buffer: one six-lane write port (a full pixel pair per edge)
// and one registered byte read port that returns zero past the end of the frame.
module image_write_frame_buffer_ram
   import image_write_pkg::*;
#(
   parameter int  DEPTH  = WIDTH_DEF * HEIGHT_DEF * BPP,
   parameter int  ADDR_W = ADDR_W_DEF,
   localparam int MEM_AW = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [MEM_AW-1:0]       wr_addr,
   input  logic [8*BEAT_BYTES-1:0] wr_data,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic [7:0]              rd_data
);

   logic [7:0] mem [DEPTH];

   // NOTE: the storage array has no reset so it maps onto plain RAM; only the read register is reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < BEAT_BYTES; i++) begin
            mem[wr_addr + MEM_AW'(i)] <= wr_data[8*i +: 8];
         end
      end
   end

   // Same-edge read of a byte being written returns the previous contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_addr < ADDR_W'(DEPTH)) begin
         rd_data <= mem[rd_addr[MEM_AW-1:0]];
      end else begin
         rd_data <= '0;
      end
   end

endmodule

// File: rtl/image_write.sv
// Frame sink: qualifies RGB888 pixel pairs with VSYNC/HSYNC and stores them
// bottom-up (BMP row order) in the frame buffer, flagging completion and overflow.
module image_write
   import image_write_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              VSYNC,
   input  logic              HSYNC,
   input  logic [7:0]        DATA_R0,
   input  logic [7:0]        DATA_G0,
   input  logic [7:0]        DATA_B0,
   input  logic [7:0]        DATA_R1,
   input  logic [7:0]        DATA_G1,
   input  logic [7:0]        DATA_B1,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              busy,
   output logic              write_done,
   output logic              overflow
);

   localparam int DEPTH  = WIDTH * HEIGHT * BPP;
   localparam int MEM_AW = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(WIDTH * HEIGHT / 2 - 1);
   localparam logic [MEM_AW-1:0] ROW_BYTES = MEM_AW'(WIDTH * BPP);
   localparam logic [MEM_AW-1:0] LAST_ROW  = MEM_AW'(HEIGHT - 1);
   localparam logic [MEM_AW-1:0] LAST_COL  = MEM_AW'(WIDTH - 2);

   state_t            state, state_next;
   logic              vsync_q;
   logic              vs_rise;
   logic              beat;
   logic              last_beat;
   logic [MEM_AW-1:0] row;
   logic [MEM_AW-1:0] col;
   logic [MEM_AW-1:0] wr_addr;
   logic [ADDR_W-1:0] pair_cnt;

   // VSYNC always wins over a coincident HSYNC, so such a beat is dropped.
   assign vs_rise   = VSYNC & ~vsync_q;
   assign busy      = (state == ST_ARMED) || (state == ST_CAPTURE);
   assign beat      = HSYNC & ~VSYNC & busy;
   assign last_beat = beat & (pair_cnt == LAST_PAIR);
   assign wr_addr   = ROW_BYTES * (LAST_ROW - row) + MEM_AW'(BPP) * col;

   // NOTE: state_next takes its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (vs_rise) state_next = ST_ARMED;
         ST_ARMED:   if (beat) state_next = last_beat ? ST_DONE : ST_CAPTURE;
         ST_CAPTURE: begin
            if (vs_rise)        state_next = ST_ARMED;
            else if (last_beat) state_next = ST_DONE;
         end
         ST_DONE:    if (vs_rise) state_next = ST_ARMED;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state      <= ST_IDLE;
         vsync_q    <= 1'b0;
         row        <= '0;
         col        <= '0;
         pair_cnt   <= '0;
         write_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state   <= state_next;
         vsync_q <= VSYNC;
         if (state_next == ST_ARMED) begin
            row        <= '0;
            col        <= '0;
            pair_cnt   <= '0;
            write_done <= 1'b0;
            overflow   <= 1'b0;
         end else begin
            // Counters freeze on the final beat so pair_cnt never wraps.
            if (beat && !last_beat) begin
               pair_cnt <= pair_cnt + ADDR_W'(1);
               if (col == LAST_COL) begin
                  col <= '0;
                  row <= row + MEM_AW'(1);
               end else begin
                  col <= col + MEM_AW'(2);
               end
            end
            if (last_beat) write_done <= 1'b1;
            if (state == ST_DONE && HSYNC && !VSYNC) overflow <= 1'b1;
         end
      end
   end

   image_write_frame_buffer_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (HCLK),
      .rst     (HRESET),
      .wr_en   (beat),
      .wr_addr (wr_addr),
      .wr_data ({DATA_B1, DATA_G1, DATA_R1, DATA_B0, DATA_G0, DATA_R0}),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_image_write.sv
// Self-checking bench for image_write (WIDTH=4, HEIGHT=2): directed vector table,
// hand-written corner sequences, and a random phase checked against a frame-level model.
module tb_image_write;

   localparam int W     = 4;
   localparam int H     = 2;
   localparam int AW    = 19;
   localparam int DEPTH = W * H * 3;
   localparam int PAIRS = W * H / 2;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic          VSYNC;
   logic          HSYNC;
   logic [7:0]    DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          busy, write_done, overflow;

   always #5 HCLK = ~HCLK;

   image_write #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .VSYNC      (VSYNC),
      .HSYNC      (HSYNC),
      .DATA_R0    (DATA_R0),
      .DATA_G0    (DATA_G0),
      .DATA_B0    (DATA_B0),
      .DATA_R1    (DATA_R1),
      .DATA_G1    (DATA_G1),
      .DATA_B1    (DATA_B1),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .write_done (write_done),
      .overflow   (overflow)
   );

   int checks = 0;
   int errors = 0;

   // Frame-level reference: mode 0 idle, 1 busy, 2 done; beats counts pairs in this frame.
   logic [7:0] m_mem [DEPTH];
   bit         m_known [DEPTH];
   int         m_mode;
   int         m_beats;
   bit         m_done, m_ovf, m_vs_prev;
   logic [7:0] exp_rd;
   bit         exp_rd_known;

   // Byte offsets of streamed pairs 0..3 in the bottom-up buffer.
   int exp_base [4] = '{12, 18, 0, 6};

   typedef struct {
      bit vs;
      bit hs;
      int k;
      bit busy;
      bit done;
      bit ovf;
   } vec_t;
   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] pat(input int k);
      logic [47:0] p;
      for (int j = 0; j < 6; j++) p[8*j +: 8] = 8'(16 * (j + 1) + k);
      return p;
   endfunction

   function automatic int beat_base(input int n);
      int r, c;
      r = n / (W / 2);
      c = 2 * (n % (W / 2));
      return W * 3 * (H - 1 - r) + 3 * c;
   endfunction

   task automatic cycle(input bit vs, input bit hs, input logic [47:0] d);
      bit rise;
      int a;
      VSYNC = vs;
      HSYNC = hs;
      {DATA_B1, DATA_G1, DATA_R1, DATA_B0, DATA_G0, DATA_R0} = d;
      a = int'(rd_addr);
      if (a >= DEPTH) begin
         exp_rd       = 8'h00;
         exp_rd_known = 1'b1;
      end else begin
         exp_rd       = m_mem[a];
         exp_rd_known = m_known[a];
      end
      rise      = vs && !m_vs_prev;
      m_vs_prev = vs;
      case (m_mode)
         0: if (rise) begin m_mode = 1; m_beats = 0; end
         1: begin
            if (rise) m_beats = 0;
            else if (hs && !vs) begin
               a = beat_base(m_beats);
               for (int j = 0; j < 6; j++) begin
                  m_mem[a + j]   = d[8*j +: 8];
                  m_known[a + j] = 1'b1;
               end
               m_beats++;
               if (m_beats == PAIRS) begin m_mode = 2; m_done = 1'b1; end
            end
         end
         default: begin
            if (rise) begin m_mode = 1; m_beats = 0; m_done = 1'b0; m_ovf = 1'b0; end
            else if (hs && !vs) m_ovf = 1'b1;
         end
      endcase
      @(posedge HCLK);
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_busy"}, busy, m_mode == 1);
      check({tag, "_done"}, write_done, m_done);
      check({tag, "_ovf"}, overflow, m_ovf);
      if (exp_rd_known) check({tag, "_rd"}, rd_data, exp_rd);
   endtask

   task automatic apply_reset(input int n);
      HRESET = 1'b1;
      #1;
      m_mode = 0; m_done = 1'b0; m_ovf = 1'b0; m_vs_prev = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", write_done, 0);
      check("rst_ovf", overflow, 0);
      check("rst_rd", rd_data, 0);
      repeat (n) @(posedge HCLK);
      #1;
      HRESET = 1'b0;
   endtask

   task automatic readout(input int off, input string tag);
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 6; j++) begin
            rd_addr = AW'(exp_base[k] + j);
            cycle(1'b0, 1'b0, '0);
            check($sformatf("%s_m%0d", tag, exp_base[k] + j), rd_data, 8'(16 * (j + 1) + k + off));
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 9, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1};

      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 8'h00; m_known[i] = 1'b0; end
      m_beats = 0;
      VSYNC = 1'b0; HSYNC = 1'b0; rd_addr = '0;
      {DATA_B1, DATA_G1, DATA_R1, DATA_B0, DATA_G0, DATA_R0} = '0;

      // Reset mid-stream, then HSYNC in idle must be ignored.
      apply_reset(2);
      cycle(1'b1, 1'b0, '0);
      cycle(1'b0, 1'b0, '0);
      cycle(1'b0, 1'b1, pat(8'h60));
      check("pre_rst_busy", busy, 1);
      HSYNC = 1'b1;
      apply_reset(3);
      cycle(1'b0, 1'b1, pat(8'hDE));
      cycle(1'b0, 1'b1, pat(8'hDE));
      check("idle_busy", busy, 0);
      check("idle_done", write_done, 0);
      rd_addr = AW'(12);
      cycle(1'b0, 1'b0, '0);
      check("idle_nowrite", rd_data, 8'h70);

      // Full frame with a row gap, then an overflow beat.
      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].vs, tbl[i].hs, pat(tbl[i].k));
         check($sformatf("t%0d_busy", i), busy, tbl[i].busy);
         check($sformatf("t%0d_done", i), write_done, tbl[i].done);
         check($sformatf("t%0d_ovf", i), overflow, tbl[i].ovf);
      end
      readout(0, "frame");

      // Registered readout latency and out-of-range address.
      rd_addr = AW'(12);
      cycle(1'b0, 1'b0, '0);
      check("rd_12", rd_data, 8'h10);
      rd_addr = AW'(24);
      cycle(1'b0, 1'b0, '0);
      check("rd_24", rd_data, 8'h00);
      rd_addr = '1;
      cycle(1'b0, 1'b0, '0);
      check("rd_max", rd_data, 8'h00);

      // Restart mid-frame: aborted beats get overwritten by the fresh frame.
      cycle(1'b1, 1'b0, '0);
      check("rs_busy", busy, 1);
      check("rs_done", write_done, 0);
      check("rs_ovf", overflow, 0);
      cycle(1'b0, 1'b0, '0);
      cycle(1'b0, 1'b1, pat(8'h80));
      cycle(1'b0, 1'b1, pat(8'h81));
      cycle(1'b1, 1'b0, '0);
      check("rs2_busy", busy, 1);
      check("rs2_done", write_done, 0);
      cycle(1'b0, 1'b0, '0);
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, 1'b1, pat(4 + k));
         check($sformatf("rs_b%0d_done", k), write_done, k == 3);
      end
      readout(4, "restart");

      // VSYNC and HSYNC together in ARMED: beat dropped, frame still needs four beats.
      cycle(1'b1, 1'b0, '0);
      cycle(1'b0, 1'b0, '0);
      cycle(1'b1, 1'b1, pat(8'hC0));
      check("ov_busy", busy, 1);
      cycle(1'b0, 1'b0, '0);
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, 1'b1, pat(8 + k));
         check($sformatf("ov_b%0d_done", k), write_done, k == 3);
      end
      readout(8, "overlap");

      // Random traffic against the model, with one reset in the middle.
      for (int i = 0; i < 400; i++) begin
         bit vs, hs;
         if (i == 200) apply_reset(3);
         vs = ($urandom_range(0, 19) == 0);
         hs = vs ? 1'b0 : ($urandom_range(0, 2) != 0);
         rd_addr = AW'($urandom_range(0, DEPTH + 3));
         cycle(vs, hs, {16'($urandom), 32'($urandom)});
         check_model($sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
